axi_in: RTL

//  AXI4-Lite write-only slave (AW/W/B channels); the CPU-to-coprocessor input path of the SNN accelerator.

---
 rtl/axi_in_pkg.sv | 16 +
 rtl/image_word_ram.sv | 51 +++++
 rtl/axi_in.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/axi_in_pkg.sv
// axi_in_pkg: shared constants and types for the axi_in write slave.
//   RESP_OKAY / RESP_SLVERR : AXI write response codes
//   DEFAULT_IMAGE_WORDS     : image words held (784 pixels / 4)
//   DEFAULT_CTRL_WORD       : word index of the control register
//   word_idx_t              : 8-bit word index used by the decode and the image RAM
package axi_in_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned DEFAULT_IMAGE_WORDS = 196;
    localparam int unsigned DEFAULT_CTRL_WORD   = 255;

    typedef logic [7:0] word_idx_t;

endpackage

// File: rtl/image_word_ram.sv
// image_word_ram: WORDS x WIDTH image storage, byte-enabled write port and a registered read port.
// Ports:
//   clk, rst : clock; asynchronous active-high reset (clears the read register only)
//   we       : write enable; waddr must be < WORDS when asserted
//   waddr    : write word index
//   wstrb    : per-byte write enables
//   wdata    : write data
//   raddr    : read word index; indices >= WORDS read as zero
//   rdata    : read data, one cycle after raddr (a same-edge write returns the old word)
module image_word_ram
    import axi_in_pkg::*;
#(
    parameter int unsigned WORDS = DEFAULT_IMAGE_WORDS,
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  word_idx_t          waddr,
    input  logic [WIDTH/8-1:0] wstrb,
    input  logic [WIDTH-1:0]   wdata,
    input  word_idx_t          raddr,
    output logic [WIDTH-1:0]   rdata
);

    localparam word_idx_t RD_LIMIT = word_idx_t'(WORDS);

    // Contents are deliberately not reset.
    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < WIDTH / 8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (raddr < RD_LIMIT) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/axi_in.sv
// axi_in: AXI4-Lite write-only slave feeding the SNN coprocessor (image words + control register).
// Ports:
//   ACLK, ARESET            : clock; asynchronous active-high reset
//   AWADDR/AWPROT/AWVALID/AWREADY : write address channel (word index = AWADDR[AXI_ADDR_WIDTH-1:2])
//   WDATA/WSTRB/WVALID/WREADY     : write data channel
//   BRESP/BVALID/BREADY     : write response channel (single outstanding write)
//   COPROCESSOR_RDY         : SNN idle; gates image writes and start commands
//   START                   : one-cycle start pulse, aligned with BVALID rising
//   IMG_RADDR / IMG_RDATA   : SNN image read port, 1-cycle latency
// Configuration macro AXI_IN_ADDR_CHECK_EN: when defined, writes to unmapped word indices answer
// SLVERR; otherwise they are dropped with OKAY.
module axi_in
    import axi_in_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 10,
    parameter int unsigned IMAGE_WORDS    = DEFAULT_IMAGE_WORDS,
    parameter int unsigned CTRL_WORD      = DEFAULT_CTRL_WORD
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [31:0]                 AWADDR,
    input  logic [2:0]                  AWPROT,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    input  logic                        COPROCESSOR_RDY,
    output logic                        START,
    input  word_idx_t                   IMG_RADDR,
    output logic [AXI_DATA_WIDTH-1:0]   IMG_RDATA
);

    localparam int unsigned SW        = AXI_DATA_WIDTH / 8;
    localparam word_idx_t   IMG_LIMIT = word_idx_t'(IMAGE_WORDS);
    localparam word_idx_t   CTRL_IDX  = word_idx_t'(CTRL_WORD);

`ifdef AXI_IN_ADDR_CHECK_EN
    localparam logic [1:0] UNMAPPED_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] UNMAPPED_RESP = RESP_OKAY;
`endif

    logic                      aw_held_q, w_held_q;
    word_idx_t                 aw_idx_q;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;
    logic [SW-1:0]             w_strb_q;
    logic                      bvalid_q, start_q;
    logic [1:0]                bresp_q;

    logic                      aw_hs, w_hs, commit;
    word_idx_t                 aw_idx_in, cur_idx;
    logic [AXI_DATA_WIDTH-1:0] cur_data;
    logic [SW-1:0]             cur_strb;
    logic                      is_img, is_ctrl, start_req, ram_we, start_d;
    logic [1:0]                resp_d;

    // Address bits outside the decoded window and AWPROT carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{AWPROT, AWADDR[31:AXI_ADDR_WIDTH], AWADDR[1:0]};

    assign AWREADY = !ARESET && !aw_held_q && !bvalid_q;
    assign WREADY  = !ARESET && !w_held_q && !bvalid_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign START   = start_q;

    always_comb begin
        aw_hs     = AWVALID && AWREADY;
        w_hs      = WVALID && WREADY;
        aw_idx_in = word_idx_t'(AWADDR[AXI_ADDR_WIDTH-1:2]);
        // A held beat takes priority; otherwise use the beat handshaking this cycle.
        cur_idx   = aw_held_q ? aw_idx_q : aw_idx_in;
        cur_data  = w_held_q ? w_data_q : WDATA;
        cur_strb  = w_held_q ? w_strb_q : WSTRB;
        commit    = (aw_held_q || aw_hs) && (w_held_q || w_hs);

        is_img    = cur_idx < IMG_LIMIT;
        is_ctrl   = cur_idx == CTRL_IDX;
        start_req = is_ctrl && cur_strb[0] && cur_data[0];

        resp_d = RESP_OKAY;
        if (is_img) begin
            if (!COPROCESSOR_RDY) resp_d = RESP_SLVERR;
        end else if (is_ctrl) begin
            if (start_req && !COPROCESSOR_RDY) resp_d = RESP_SLVERR;
        end else begin
            resp_d = UNMAPPED_RESP;
        end

        ram_we  = commit && is_img && COPROCESSOR_RDY;
        start_d = commit && start_req && COPROCESSOR_RDY;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            start_q   <= 1'b0;
        end else begin
            start_q <= start_d;
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= resp_d;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_idx_q  <= aw_idx_in;
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    w_data_q <= WDATA;
                    w_strb_q <= WSTRB;
                end
                if (bvalid_q && BREADY) bvalid_q <= 1'b0;
            end
        end
    end

    image_word_ram #(
        .WORDS (IMAGE_WORDS),
        .WIDTH (AXI_DATA_WIDTH)
    ) u_ram (
        .clk   (ACLK),
        .rst   (ARESET),
        .we    (ram_we),
        .waddr (cur_idx),
        .wstrb (cur_strb),
        .wdata (cur_data),
        .raddr (IMG_RADDR),
        .rdata (IMG_RDATA)
    );

endmodule
